// File: rtl/imem_access_ctrl_pkg.sv
// Shared definitions for the instruction-memory access controller:
// FSM encodings, memory RW polarity, arbiter grant codes, sizing helpers.
package imem_access_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_RD         = 3'd1;
  localparam state_t S_WR_SETUP   = 3'd2;
  localparam state_t S_WR_STROBE  = 3'd3;
  localparam state_t S_WR_RECOVER = 3'd4;

  // Memory RW pin polarity: high reads, low writes.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Requester identities as used by the round-robin arbiter.
  localparam logic GRANT_FETCH  = 1'b0;
  localparam logic GRANT_LOADER = 1'b1;

  localparam int MEM_BYTES_DEFAULT = 301;

  // Highest word-aligned byte address whose whole word fits in the memory.
  function automatic logic [31:0] last_word_addr(input int mem_bytes);
    return 32'((mem_bytes - 4) & ~3);
  endfunction

  // A request is legal when word aligned and not beyond the last word.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] last_word);
    return (addr[1:0] == 2'b00) && (addr <= last_word);
  endfunction

endpackage

// File: rtl/imem_access_ctrl_if.sv
// Bundle of requester handshakes and memory-port signals for imem_access_ctrl.
//
// Handshake: a requester raises req together with addr (and wdata for the
// loader) and holds all of them unchanged until the controller returns a
// single-cycle ack; err qualifies that ack and is 0 whenever ack is 0. There
// is no separate ready: a request is only taken while the controller is idle
// and its previous ack is not being driven in that same cycle.
interface imem_access_ctrl_if;
  import imem_access_ctrl_pkg::*;

  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        f_err;

  logic        l_req;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_ack;
  logic        l_err;

  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  state_t      dbg_state;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    output f_ack, f_rdata, f_err, l_ack, l_err, busy,
           mem_addr, mem_wdata, mem_rw, dbg_state
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    input  f_ack, f_rdata, f_err, l_ack, l_err, busy,
           mem_addr, mem_wdata, mem_rw, dbg_state
  );

endinterface

// File: rtl/imem_access_ctrl_rr_arb.sv
// Two-way round-robin picker. Purely combinational; the last-grant flop
// lives in the parent so the grant history survives only real grants.
module imem_access_ctrl_rr_arb
  import imem_access_ctrl_pkg::*;
(
  input  logic [1:0] i_elig,        // bit 0 = fetch, bit 1 = loader
  input  logic       i_last_grant,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  // Lone requester wins; on contention the one not granted last time wins.
  always_comb begin
    o_gnt_valid = |i_elig;
    o_gnt_id    = GRANT_FETCH;
    case (i_elig)
      2'b01:   o_gnt_id = GRANT_FETCH;
      2'b10:   o_gnt_id = GRANT_LOADER;
      2'b11:   o_gnt_id = (i_last_grant == GRANT_FETCH) ? GRANT_LOADER : GRANT_FETCH;
      default: o_gnt_id = GRANT_FETCH;
    endcase
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Sequencer/arbiter in front of the byte-addressed instruction memory.
// Fetch reads take one memory cycle; loader writes go through setup,
// a single-cycle strobe and a recovery cycle so address and data are
// stable around the RW low pulse. Illegal requests are answered with
// ack+err one cycle later without touching the memory pins.
module imem_access_ctrl
  import imem_access_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
)
(
  input logic                CLK,
  input logic                Reset,
  imem_access_ctrl_if.slave  bus
);

  localparam logic [31:0] LAST_WORD = last_word_addr(MEM_BYTES);

  state_t      r_state;
  logic        r_last_grant;
  logic        r_f_ack;
  logic        r_f_err;
  logic [31:0] r_f_rdata;
  logic        r_l_ack;
  logic        r_l_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_rw;

  logic [1:0]  w_elig;
  logic        w_gnt_valid;
  logic        w_gnt_id;
  logic [31:0] w_sel_addr;
  logic        w_legal;

  // A requester whose ack is high this cycle is still holding the old
  // request, so it must not be re-granted yet.
  assign w_elig[0] = bus.f_req & ~r_f_ack;
  assign w_elig[1] = bus.l_req & ~r_l_ack;

  imem_access_ctrl_rr_arb u_arb (
    .i_elig       (w_elig),
    .i_last_grant (r_last_grant),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_id     (w_gnt_id)
  );

  assign w_sel_addr = (w_gnt_id == GRANT_FETCH) ? bus.f_addr : bus.l_addr;
  assign w_legal    = addr_legal(w_sel_addr, LAST_WORD);

  // Main FSM: grant/check in IDLE, then walk the read or write sequence.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_LOADER;
      r_f_ack      <= 1'b0;
      r_f_err      <= 1'b0;
      r_f_rdata    <= 32'd0;
      r_l_ack      <= 1'b0;
      r_l_err      <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_rw     <= RW_READ;
    end else begin
      r_f_ack <= 1'b0;
      r_f_err <= 1'b0;
      r_l_ack <= 1'b0;
      r_l_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_last_grant <= w_gnt_id;
            if (w_gnt_id == GRANT_FETCH) begin
              if (w_legal) begin
                r_mem_addr <= bus.f_addr;
                r_state    <= S_RD;
              end else begin
                r_f_ack <= 1'b1;
                r_f_err <= 1'b1;
              end
            end else begin
              if (w_legal) begin
                r_mem_addr  <= bus.l_addr;
                r_mem_wdata <= bus.l_wdata;
                r_mem_rw    <= RW_READ;
                r_state     <= S_WR_SETUP;
              end else begin
                r_l_ack <= 1'b1;
                r_l_err <= 1'b1;
              end
            end
          end
        end
        S_RD: begin
          r_f_rdata <= bus.mem_rdata;
          r_f_ack   <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_WR_SETUP: begin
          r_mem_rw <= RW_WRITE;
          r_state  <= S_WR_STROBE;
        end
        S_WR_STROBE: begin
          r_mem_rw <= RW_READ;
          r_state  <= S_WR_RECOVER;
        end
        S_WR_RECOVER: begin
          r_l_ack <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_rw <= RW_READ;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.f_ack     = r_f_ack;
  assign bus.f_err     = r_f_err;
  assign bus.f_rdata   = r_f_rdata;
  assign bus.l_ack     = r_l_ack;
  assign bus.l_err     = r_l_err;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_rw    = r_mem_rw;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: word-array memory model on the memory pins,
// driver tasks for both requesters, expected-result queues popped on acks.
module tb_imem_access_ctrl;
  import imem_access_ctrl_pkg::*;

  localparam int MEM_BYTES = 301;

  logic CLK = 1'b0;
  logic Reset = 1'b1;

  imem_access_ctrl_if bus();

  imem_access_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  task automatic apply_reset();
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_words [0:127];
  logic        rst_at_edge = 1'b1;

  assign bus.mem_rdata = mem_words[bus.mem_addr[8:2]];

  always @(posedge CLK) begin
    rst_at_edge = Reset;
    if (bus.mem_rw == 1'b0) mem_words[bus.mem_addr[8:2]] = bus.mem_wdata;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] f_exp_q[$];   // {err, rdata}
  logic [0:0]  l_exp_q[$];   // err
  logic [0:0]  order_q[$];   // expected requester of next ack (arbitration test)
  logic [32:0] f_e;
  logic [0:0]  l_e;
  logic [0:0]  o_e;
  logic [31:0] prev_addr  = 32'd0;
  logic        prev_rw    = 1'b1;
  state_t      prev_state = S_IDLE;
  bit          mon_en     = 1'b0;

  always @(negedge CLK) begin
    if (mon_en) begin
      check("rw_low_only_in_strobe", 64'(!bus.mem_rw && bus.dbg_state != S_WR_STROBE), 64'd0);
      check("acks_exclusive", 64'(bus.f_ack && bus.l_ack), 64'd0);
      check("f_err_without_ack", 64'(bus.f_err && !bus.f_ack), 64'd0);
      check("l_err_without_ack", 64'(bus.l_err && !bus.l_ack), 64'd0);
      if (!rst_at_edge && bus.mem_addr != prev_addr)
        check("addr_change_edge",
              64'(prev_state == S_IDLE && prev_rw &&
                  (bus.dbg_state == S_RD || bus.dbg_state == S_WR_SETUP)), 64'd1);
      if (bus.f_ack) begin
        if (f_exp_q.size() == 0) check("f_ack_unexpected", 64'd1, 64'd0);
        else begin
          f_e = f_exp_q.pop_front();
          check("f_err", 64'(bus.f_err), 64'(f_e[32]));
          if (!f_e[32]) check("f_rdata", 64'(bus.f_rdata), 64'(f_e[31:0]));
        end
        if (order_q.size() != 0) begin
          o_e = order_q.pop_front();
          check("grant_order", 64'(GRANT_FETCH), 64'(o_e));
        end
      end
      if (bus.l_ack) begin
        if (l_exp_q.size() == 0) check("l_ack_unexpected", 64'd1, 64'd0);
        else begin
          l_e = l_exp_q.pop_front();
          check("l_err", 64'(bus.l_err), 64'(l_e));
        end
        if (order_q.size() != 0) begin
          o_e = order_q.pop_front();
          check("grant_order", 64'(GRANT_LOADER), 64'(o_e));
        end
      end
    end
    prev_addr  = bus.mem_addr;
    prev_rw    = bus.mem_rw;
    prev_state = bus.dbg_state;
  end

  // ---------------- drivers (called right after a falling edge) ----------------
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                          input bit exp_err, input string tag);
    int lat;
    bit rw_low;
    logic [31:0] addr0;
    addr0  = bus.mem_addr;
    lat    = 0;
    rw_low = 1'b0;
    f_exp_q.push_back({exp_err, exp_data});
    bus.f_addr = addr;
    bus.f_req  = 1'b1;
    while (lat < 20) begin
      @(negedge CLK);
      lat++;
      if (!bus.mem_rw) rw_low = 1'b1;
      if (bus.f_ack) break;
    end
    check({tag, "_latency"}, 64'(lat), exp_err ? 64'd1 : 64'd2);
    check({tag, "_rw_stays_read"}, 64'(rw_low), 64'd0);
    if (exp_err) check({tag, "_addr_kept"}, 64'(bus.mem_addr), 64'(addr0));
    bus.f_req = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data,
                         input bit exp_err, input string tag);
    int lat;
    bit rw_low;
    logic [31:0] addr0;
    addr0  = bus.mem_addr;
    lat    = 0;
    rw_low = 1'b0;
    l_exp_q.push_back(exp_err);
    bus.l_addr  = addr;
    bus.l_wdata = data;
    bus.l_req   = 1'b1;
    while (lat < 20) begin
      @(negedge CLK);
      lat++;
      if (!bus.mem_rw) rw_low = 1'b1;
      if (!exp_err && lat <= 3) begin
        check({tag, "_addr_stable"}, 64'(bus.mem_addr), 64'(addr));
        check({tag, "_wdata_stable"}, 64'(bus.mem_wdata), 64'(data));
        check({tag, "_rw_cycle"}, 64'(bus.mem_rw), 64'(lat != 2));
      end
      if (bus.l_ack) break;
    end
    check({tag, "_latency"}, 64'(lat), exp_err ? 64'd1 : 64'd4);
    if (exp_err) begin
      check({tag, "_rw_stays_read"}, 64'(rw_low), 64'd0);
      check({tag, "_addr_kept"}, 64'(bus.mem_addr), 64'(addr0));
    end
    bus.l_req = 1'b0;
    @(negedge CLK);
  endtask

  // ---------------- test sequence ----------------
  int ack_times [4] = '{2, 6, 8, 12};
  int n_acks;
  int cyc;

  initial begin
    for (int i = 0; i < 128; i++) mem_words[i] = 32'd0;
    mem_words[2] = 32'h2001_0005;
    mem_words[8] = 32'h1111_2222;
    bus.f_req   = 1'b0;
    bus.f_addr  = 32'd0;
    bus.l_req   = 1'b0;
    bus.l_addr  = 32'd0;
    bus.l_wdata = 32'd0;

    @(negedge CLK);
    apply_reset();
    check("rst_mem_rw", 64'(bus.mem_rw), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_acks_errs", 64'({bus.f_ack, bus.f_err, bus.l_ack, bus.l_err}), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_f_rdata", 64'(bus.f_rdata), 64'd0);
    mon_en = 1'b1;

    // Plain fetch, then write/read-back.
    do_fetch(32'h8, 32'h2001_0005, 1'b0, "fetch_8");
    do_load(32'h10, 32'hDEAD_BEEF, 1'b0, "load_10");
    do_fetch(32'h10, 32'hDEAD_BEEF, 1'b0, "fetch_10");

    // Illegal requests and the top-of-memory boundary.
    do_fetch(32'h6, 32'd0, 1'b1, "fetch_misaligned");
    do_load(32'd300, 32'h0BAD_0BAD, 1'b1, "load_out_of_range");
    do_load(32'd296, 32'hA5A5_0128, 1'b0, "load_last_word");
    do_fetch(32'd296, 32'hA5A5_0128, 1'b0, "fetch_last_word");
    do_fetch(32'd297, 32'd0, 1'b1, "fetch_297");
    do_fetch(32'd300, 32'd0, 1'b1, "fetch_300");

    // Random legal load/fetch pairs.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'($urandom_range(0, 74)) << 2;
      d = $urandom;
      do_load(a, d, 1'b0, "load_rand");
      do_fetch(a, d, 1'b0, "fetch_rand");
    end

    // Both requesters held from reset: fetch, loader, fetch, loader.
    apply_reset();
    f_exp_q.push_back({1'b0, 32'h1111_2222});
    f_exp_q.push_back({1'b0, 32'h1111_2222});
    l_exp_q.push_back(1'b0);
    l_exp_q.push_back(1'b0);
    order_q.push_back(GRANT_FETCH);
    order_q.push_back(GRANT_LOADER);
    order_q.push_back(GRANT_FETCH);
    order_q.push_back(GRANT_LOADER);
    bus.f_addr  = 32'h20;
    bus.l_addr  = 32'h24;
    bus.l_wdata = 32'hCAFE_0001;
    bus.f_req   = 1'b1;
    bus.l_req   = 1'b1;
    n_acks = 0;
    cyc    = 0;
    while (n_acks < 4 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (bus.f_ack || bus.l_ack) begin
        check("arb_ack_time", 64'(cyc), 64'(ack_times[n_acks]));
        n_acks++;
      end
    end
    check("arb_ack_count", 64'(n_acks), 64'd4);
    bus.f_req = 1'b0;
    bus.l_req = 1'b0;
    @(negedge CLK);
    check("arb_order_drained", 64'(order_q.size()), 64'd0);
    check("arb_wrote_loader_word", 64'(mem_words[9]), 64'hCAFE_0001);

    // Reset while the write strobe is low: aborted, no ack, then retry.
    bus.l_addr  = 32'h40;
    bus.l_wdata = 32'h55AA_55AA;
    bus.l_req   = 1'b1;
    repeat (2) @(negedge CLK);
    check("abort_reached_strobe", 64'(bus.mem_rw), 64'd0);
    Reset     = 1'b1;
    bus.l_req = 1'b0;
    @(negedge CLK);
    check("abort_rw_read", 64'(bus.mem_rw), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_no_ack", 64'(bus.l_ack), 64'd0);
    Reset = 1'b0;
    repeat (4) @(negedge CLK);
    do_load(32'h40, 32'h1234_5678, 1'b0, "load_after_abort");
    do_fetch(32'h40, 32'h1234_5678, 1'b0, "fetch_after_abort");

    check("f_queue_empty", 64'(f_exp_q.size()), 64'd0);
    check("l_queue_empty", 64'(l_exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
